// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 16x-oversampling UART receiver front end; UART_RX_PARITY_EN selects 8E1 with parity_err
module uart_rx_deserializer #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 326
) (
    input  logic       top_clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_done_tick,
    output logic [7:0] rx_bus,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

    state_t           state_q, state_d;
    logic             rx_meta_q, rx_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [3:0]       s_q, s_d;
    logic [2:0]       n_q, n_d;
    logic [7:0]       b_q, b_d;
    logic [7:0]       bus_q, bus_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    always_comb begin
        tick  = (div_q == DIV_W'(BAUD_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        bus_d   = bus_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Start edge is seen on top_clk so the start bit is centred to within one tick
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s_q) begin
                            s_d     = '0;
                            n_d     = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[7:1]};
                        if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PAR;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PAR: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = '0;
                        par_d   = rx_s_q;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            if ((^b_q) ^ par_q) begin
                                perr_d = 1'b1;
                            end else begin
                                bus_d  = b_q;
                                done_d = 1'b1;
                            end
`else
                            bus_d  = b_q;
                            done_d = 1'b1;
`endif
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HI;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            WAIT_HI: begin
                // A held-low line (break) must go high before another start is accepted
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge top_clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            div_q     <= '0;
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            bus_q     <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            div_q     <= div_d;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            bus_q     <= bus_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_done_tick = done_q;
    assign rx_bus       = bus_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for uart_rx_deserializer (default build or UART_RX_PARITY_EN)
module tb_uart_rx_deserializer;

    localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       top_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic       rx_done_tick;
    logic [7:0] rx_bus;
    logic       frame_err;
    logic       parity_err;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int excl_bad = 0;
    int width_bad = 0;
    logic prev_done = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_bus;
    } vec_t;
    vec_t vecs[6];

    uart_rx_deserializer #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
        .top_clk      (top_clk),
        .reset        (reset),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .rx_bus       (rx_bus),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .frame_err    (frame_err)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 top_clk = ~top_clk;

    always @(negedge top_clk) begin
        if (rx_done_tick) begin
            done_cnt++;
            got_q.push_back(rx_bus);
        end
        if (frame_err) ferr_cnt++;
        if (parity_err) perr_cnt++;
        if (rx_done_tick && (frame_err || parity_err)) excl_bad++;
        if (rx_done_tick && prev_done) width_bad++;
        prev_done = rx_done_tick;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge top_clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT);
        end
        if (PAR_EN) begin
            rx = (^d) ^ par_flip;
            wait_clks(BIT);
        end
        rx = stop_bit;
        wait_clks(BIT);
        rx = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_bit,
                             input logic par_flip, input int gap);
        int d0, f0, p0, ed, ef, ep;
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        ef = stop_bit ? 0 : 1;
        ep = (stop_bit && PAR_EN && par_flip) ? 1 : 0;
        ed = (stop_bit && !(PAR_EN && par_flip)) ? 1 : 0;
        if (ed == 1) last_good = d;
        send_frame(d, stop_bit, par_flip);
        wait_clks(gap);
        check({tag, "_done"}, done_cnt - d0, ed);
        check({tag, "_ferr"}, ferr_cnt - f0, ef);
        check({tag, "_perr"}, perr_cnt - p0, ep);
        check({tag, "_bus"}, int'(rx_bus), int'(last_good));
        if (ed == 1 && got_q.size() > 0) check({tag, "_byte"}, int'(got_q[$]), int'(d));
    endtask

    initial begin
        int d0, f0, p0, sz;
        vecs[0] = '{8'h63, 1'b1, 1, 0, 8'h63};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[2] = '{8'h5A, 1'b0, 0, 1, 8'hFF};
        vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[4] = '{8'h80, 1'b1, 1, 0, 8'h80};
        vecs[5] = '{8'h01, 1'b0, 0, 1, 8'h80};

        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(4);
        check("reset_bus", int'(rx_bus), 0);
        check("reset_done", int'(rx_done_tick), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_perr", int'(parity_err), 0);
        reset = 1'b0;
        wait_clks(BIT);

        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt; f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0);
            wait_clks(40);
            check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_bus", i), int'(rx_bus), int'(vecs[i].exp_bus));
        end
        last_good = 8'h80;

        d0 = done_cnt;
        send_frame(8'h73, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        wait_clks(40);
        last_good = 8'h00;
        check("b2b_done", done_cnt - d0, 2);
        sz = got_q.size();
        if (sz >= 2) begin
            check("b2b_first", int'(got_q[sz-2]), 8'h73);
            check("b2b_second", int'(got_q[sz-1]), 8'h00);
        end else begin
            check("b2b_qsize", sz, 2);
        end

        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_perr", perr_cnt - p0, 0);
        run_frame("after_glitch", 8'hA5, 1'b1, 1'b0, 40);

        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(20 * BIT);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_done", done_cnt - d0, 0);
        check("break_bus", int'(rx_bus), int'(last_good));
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("break_ferr_after", ferr_cnt - f0, 1);
        run_frame("after_break", 8'h3C, 1'b1, 1'b0, 40);

`ifdef UART_RX_PARITY_EN
        run_frame("par_bad", 8'h63, 1'b1, 1'b1, 40);
        run_frame("par_good", 8'h63, 1'b1, 1'b0, 40);
        run_frame("par_bad_stop", 8'h63, 1'b0, 1'b1, 40);
`endif

        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(BIT);
        rx = 1'b1;
        wait_clks(4 * BIT + BIT / 2);
        reset = 1'b1;
        wait_clks(2);
        check("rstmid_bus", int'(rx_bus), 0);
        check("rstmid_done", int'(rx_done_tick), 0);
        check("rstmid_ferr", int'(frame_err), 0);
        reset = 1'b0;
        last_good = 8'h00;
        wait_clks(BIT / 2 + 4 * BIT);
        check("rstmid_no_pulse", done_cnt - d0, 0);
        check("rstmid_no_ferr", ferr_cnt - f0, 0);
        check("rstmid_bus_hold", int'(rx_bus), 0);
        run_frame("after_reset", 8'h55, 1'b1, 1'b0, 40);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic       sb, pf;
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            pf = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rnd%0d", i), d, sb, pf, int'($urandom_range(20, 100)));
        end

        check("pulse_exclusive", excl_bad, 0);
        check("done_width", width_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
